// File: rtl/net_batch_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | net_batch_sequencer_if : Avalon-MM slave CSR bus for the sequencer    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface net_batch_sequencer_if;
  logic [3:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_readdata;
  logic [31:0] avs_s0_writedata;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata
  );
endinterface
`default_nettype wire

// File: rtl/net_batch_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | net_batch_sequencer : queued batch front/back end for runNetwork      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module net_batch_sequencer #(
  parameter int DEPTH   = 16,
  parameter int NET_LAT = 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  net_batch_sequencer_if.slave    avs,
  output logic [63:0]             net_in,
  input  wire logic [31:0]        net_out,
  output logic                    irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (NET_LAT > 1) ? $clog2(NET_LAT) : 1;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;

  logic [63:0]   r_in_mem [DEPTH];
  logic [31:0]   r_out_mem [DEPTH];
  logic [PW-1:0] r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [CW-1:0] r_in_cnt, r_out_cnt;
  logic [31:0]   r_a_stage;
  logic [63:0]   r_net_in;
  logic [1:0]    r_state;
  logic [WW-1:0] r_wcnt;
  logic          r_run, r_done, r_in_ovf, r_out_udf, r_irq_en;

  logic w_push_req, w_rd_res, w_wr_stat, w_wr_ctrl, w_clear, w_start;
  logic w_in_full, w_in_push, w_in_pop, w_out_empty, w_out_pop, w_out_push;
  logic w_more, w_room_idle, w_room_wait, w_finish;
  logic [31:0] w_stat;

  assign w_push_req = avs.avs_s0_write & (avs.avs_s0_address == 4'd1);
  assign w_rd_res   = avs.avs_s0_read  & (avs.avs_s0_address == 4'd2);
  assign w_wr_stat  = avs.avs_s0_write & (avs.avs_s0_address == 4'd3);
  assign w_wr_ctrl  = avs.avs_s0_write & (avs.avs_s0_address == 4'd4);
  assign w_clear    = w_wr_ctrl & avs.avs_s0_writedata[1];
  assign w_start    = w_wr_ctrl & avs.avs_s0_writedata[0] & ~avs.avs_s0_writedata[1] & ~r_run;

  assign w_in_full   = (r_in_cnt == c_FULL);
  assign w_in_push   = w_push_req & ~w_in_full;
  assign w_in_pop    = (r_state == c_ISSUE);
  assign w_out_empty = (r_out_cnt == '0);
  assign w_out_pop   = w_rd_res & ~w_out_empty;
  assign w_out_push  = (r_state == c_WAIT) & (r_wcnt == '0);

  // Room checks ignore a same-cycle host pop; WAIT also reserves the slot it is filling now.
  assign w_more      = r_run & (r_in_cnt != '0);
  assign w_room_idle = (r_out_cnt != c_FULL);
  assign w_room_wait = (r_out_cnt < (c_FULL - CW'(1)));
  assign w_finish    = (r_state == c_IDLE) & r_run & (r_in_cnt == '0) & ~w_clear;

  always_ff @(posedge clk) begin
    if (w_in_push) r_in_mem[r_in_wp] <= {r_a_stage, avs.avs_s0_writedata};
    if (w_out_push) r_out_mem[r_out_wp] <= net_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else if (w_clear) begin
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_push)  r_in_wp  <= r_in_wp + PW'(1);
      if (w_in_pop)   r_in_rp  <= r_in_rp + PW'(1);
      if (w_out_push) r_out_wp <= r_out_wp + PW'(1);
      if (w_out_pop)  r_out_rp <= r_out_rp + PW'(1);
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + CW'(1);
        2'b01:   r_in_cnt <= r_in_cnt - CW'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_wcnt   <= '0;
      r_net_in <= '0;
    end else if (w_clear) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: if (w_more && w_room_idle) r_state <= c_ISSUE;
        c_ISSUE: begin
          r_net_in <= r_in_mem[r_in_rp];
          r_wcnt   <= WW'(NET_LAT - 1);
          r_state  <= c_WAIT;
        end
        c_WAIT: begin
          if (r_wcnt != '0) r_wcnt <= r_wcnt - WW'(1);
          else r_state <= (w_more && w_room_wait) ? c_ISSUE : c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_stage <= '0;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
      r_in_ovf  <= 1'b0;
      r_out_udf <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (avs.avs_s0_write && avs.avs_s0_address == 4'd0) r_a_stage <= avs.avs_s0_writedata;
      if (w_wr_ctrl) r_irq_en <= avs.avs_s0_writedata[2];

      if (w_clear || w_finish) r_run <= 1'b0;
      else if (w_start)        r_run <= 1'b1;

      // Events win over a coincident write-1-clear so none is lost.
      if (w_start)                                   r_done <= 1'b0;
      else if (w_finish)                             r_done <= 1'b1;
      else if (w_wr_stat && avs.avs_s0_writedata[17]) r_done <= 1'b0;

      if (w_push_req && w_in_full)                   r_in_ovf <= 1'b1;
      else if (w_wr_stat && avs.avs_s0_writedata[18]) r_in_ovf <= 1'b0;

      if (w_rd_res && w_out_empty)                   r_out_udf <= 1'b1;
      else if (w_wr_stat && avs.avs_s0_writedata[19]) r_out_udf <= 1'b0;
    end
  end

  assign w_stat = {12'd0, r_out_udf, r_in_ovf, r_done, r_run, 8'(r_out_cnt), 8'(r_in_cnt)};

  always_comb begin
    avs.avs_s0_readdata = 32'd0;
    if (avs.avs_s0_read) begin
      case (avs.avs_s0_address)
        4'd0:    avs.avs_s0_readdata = r_a_stage;
        4'd2:    avs.avs_s0_readdata = w_out_empty ? 32'd0 : r_out_mem[r_out_rp];
        4'd3:    avs.avs_s0_readdata = w_stat;
        4'd4:    avs.avs_s0_readdata = {29'd0, r_irq_en, 1'b0, r_run};
        default: avs.avs_s0_readdata = 32'd0;
      endcase
    end
  end

  assign net_in = r_net_in;
  assign irq    = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_net_batch_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Bench: two sequencers (DEPTH 16/NET_LAT 1 and DEPTH 4/NET_LAT 3) driven over the CSR bus;
// results are checked against a scoreboard queue filled at push time.
module tb_net_batch_sequencer;
  localparam int DA = 16, LA = 1, DB = 4, LB = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  net_batch_sequencer_if ifa();
  net_batch_sequencer_if ifb();
  logic [63:0] net_in_a, net_in_b, r_d1, r_d2;
  logic [31:0] net_out_a, net_out_b;
  logic        irq_a, irq_b;

  function automatic logic [31:0] netf(input logic [63:0] x);
    return x[63:32] * 32'd7 + x[31:0];
  endfunction

  // DUT A sees a combinational network; DUT B a network whose result settles NET_LAT cycles late.
  assign net_out_a = netf(net_in_a);
  always @(posedge clk) begin
    r_d1 <= net_in_b;
    r_d2 <= r_d1;
  end
  assign net_out_b = netf(r_d2);

  net_batch_sequencer #(.DEPTH(DA), .NET_LAT(LA)) u_a (
    .clk(clk), .reset(reset), .avs(ifa), .net_in(net_in_a), .net_out(net_out_a), .irq(irq_a));
  net_batch_sequencer #(.DEPTH(DB), .NET_LAT(LB)) u_b (
    .clk(clk), .reset(reset), .avs(ifb), .net_in(net_in_b), .net_out(net_out_b), .irq(irq_b));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [4];
  int checks = 0;
  int errors = 0;
  logic [31:0] sbq_a [$];
  logic [31:0] sbq_b [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int d, input logic rd, input logic wr, input logic [3:0] ad,
                     input logic [31:0] wd);
    if (d == 0) begin
      ifa.avs_s0_read = rd; ifa.avs_s0_write = wr;
      ifa.avs_s0_address = ad; ifa.avs_s0_writedata = wd;
    end else begin
      ifb.avs_s0_read = rd; ifb.avs_s0_write = wr;
      ifb.avs_s0_address = ad; ifb.avs_s0_writedata = wd;
    end
  endtask

  task automatic bus_wr(input int d, input logic [3:0] ad, input logic [31:0] wd);
    drv(d, 1'b0, 1'b1, ad, wd);
    @(posedge clk); #1;
    drv(d, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic bus_rd(input int d, input logic [3:0] ad, output logic [31:0] q);
    drv(d, 1'b1, 1'b0, ad, 32'd0);
    @(negedge clk);
    q = (d == 0) ? ifa.avs_s0_readdata : ifb.avs_s0_readdata;
    @(posedge clk); #1;
    drv(d, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic push_pair(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit sb);
    bus_wr(d, 4'd0, a);
    bus_wr(d, 4'd1, b);
    if (sb) begin
      if (d == 0) sbq_a.push_back(exp);
      else        sbq_b.push_back(exp);
    end
  endtask

  task automatic pop_chk(input int d, input string nm);
    logic [31:0] q, e;
    bus_rd(d, 4'd2, q);
    e = 32'hDEAD_BEEF;
    if (d == 0 && sbq_a.size() > 0) e = sbq_a.pop_front();
    if (d == 1 && sbq_b.size() > 0) e = sbq_b.pop_front();
    chk(nm, q, e);
  endtask

  task automatic wait_stat(input int d, input logic [31:0] mask, input logic [31:0] val,
                           input int maxn, input string nm);
    logic [31:0] q;
    for (int n = 0; n < maxn; n++) begin
      bus_rd(d, 4'd3, q);
      if ((q & mask) == val) break;
    end
    chk(nm, q & mask, val);
  endtask

  task automatic wait_netin(input int d, input logic [63:0] val, input int maxn, input string nm);
    logic [63:0] cur;
    cur = 64'd0;
    for (int n = 0; n < maxn; n++) begin
      @(negedge clk);
      cur = (d == 0) ? net_in_a : net_in_b;
      if (cur == val) break;
    end
    chk(nm, cur, val);
  endtask

  // Batch of the four table vectors; also measures spacing between successive issues.
  task automatic batch_test(input int d);
    logic [31:0] q;
    logic [63:0] prev, cur;
    int when [8];
    int ncg, lat;
    lat = (d == 0) ? LA : LB;
    for (int i = 0; i < 4; i++) push_pair(d, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);
    if (d == 0) begin
      bus_rd(0, 4'd0, q); chk("a_stage_read", q, 32'd100);
      bus_rd(0, 4'd1, q); chk("b_read_zero", q, 32'd0);
      bus_rd(0, 4'd9, q); chk("unmapped_read", q, 32'd0);
    end
    bus_wr(d, 4'd4, 32'h5);
    prev = (d == 0) ? net_in_a : net_in_b;
    ncg = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cur = (d == 0) ? net_in_a : net_in_b;
      if (cur !== prev) begin
        if (ncg < 8) when[ncg] = c;
        ncg++;
        prev = cur;
      end
    end
    @(posedge clk); #1;
    chk("batch_issue_count", 64'(ncg), 64'd4);
    for (int k = 1; k < 4 && k < ncg; k++)
      chk("batch_issue_spacing", 64'(when[k] - when[k-1]), 64'(lat + 1));
    bus_rd(d, 4'd3, q); chk("batch_stat_done", q, 32'h0002_0400);
    chk("batch_irq_set", (d == 0) ? irq_a : irq_b, 1'b1);
    for (int i = 0; i < 4; i++) pop_chk(d, "batch_result");
    bus_wr(d, 4'd3, 32'h0002_0000);
    bus_rd(d, 4'd3, q); chk("done_w1c", q, 32'd0);
    chk("irq_cleared", (d == 0) ? irq_a : irq_b, 1'b0);
  endtask

  initial begin
    logic [31:0] q;
    tbl[0] = '{32'd1,   32'd2, 32'd9};
    tbl[1] = '{32'd3,   32'd4, 32'd25};
    tbl[2] = '{32'd5,   32'd6, 32'd41};
    tbl[3] = '{32'd100, 32'd7, 32'd707};
    drv(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    chk("rst_net_in", net_in_a, 64'd0);
    chk("rst_irq", irq_a, 1'b0);
    bus_rd(0, 4'd3, q); chk("rst_stat_a", q, 32'd0);
    bus_rd(1, 4'd3, q); chk("rst_stat_b", q, 32'd0);
    bus_rd(0, 4'd4, q); chk("rst_ctrl_a", q, 32'd0);

    batch_test(0);

    bus_rd(0, 4'd2, q); chk("udf_read_zero", q, 32'd0);
    bus_rd(0, 4'd3, q); chk("udf_stat", q, 32'h0008_0000);
    bus_wr(0, 4'd3, 32'h0008_0000);

    for (int i = 0; i < DA; i++)
      push_pair(0, 32'(i + 10), 32'(i * 3), 32'(10 * i + 70), 1'b1);
    push_pair(0, 32'd999, 32'd999, 32'd0, 1'b0);
    bus_rd(0, 4'd3, q); chk("ovf_stat", q, 32'h0004_0010);
    drv(0, 1'b0, 1'b0, 4'd3, 32'd0);
    #1 chk("readdata_idle_zero", ifa.avs_s0_readdata, 32'd0);
    bus_wr(0, 4'd3, 32'h0004_0000);
    bus_rd(0, 4'd3, q); chk("ovf_w1c", q, 32'h0000_0010);

    bus_wr(0, 4'd4, 32'h5);
    repeat (10) @(posedge clk);
    #1;
    for (int i = DA; i < DA + 4; i++)
      push_pair(0, 32'(i + 10), 32'(i * 3), 32'(10 * i + 70), 1'b1);
    wait_stat(0, 32'h0000_FF00, 32'h0000_1000, 100, "stall_out_full");
    repeat (10) @(posedge clk);
    #1;
    bus_rd(0, 4'd3, q); chk("stall_stat", q, 32'h0001_1004);
    pop_chk(0, "stall_pop");
    repeat (6) @(posedge clk);
    #1;
    bus_rd(0, 4'd3, q); chk("stall_resume", q, 32'h0001_1003);
    for (int i = 0; i < DA + 3; i++) begin
      pop_chk(0, "drain_result");
      repeat (3) @(posedge clk);
      #1;
    end
    wait_stat(0, 32'h0003_0000, 32'h0002_0000, 50, "drain_done");
    bus_rd(0, 4'd3, q); chk("drain_stat", q, 32'h0002_0000);
    chk("drain_irq", irq_a, 1'b1);

    batch_test(1);

    for (int i = 0; i < 4; i++) push_pair(1, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);
    bus_wr(1, 4'd4, 32'h1);
    wait_netin(1, {tbl[1].a, tbl[1].b}, 40, "clear_reach_second");
    bus_wr(1, 4'd4, 32'h2);
    sbq_b.delete();
    bus_rd(1, 4'd3, q); chk("clear_stat", q, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    bus_rd(1, 4'd3, q); chk("clear_no_result", q, 32'd0);
    chk("clear_net_in_held", net_in_b, {tbl[1].a, tbl[1].b});

    for (int i = 0; i < 4; i++) push_pair(1, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
    bus_wr(1, 4'd4, 32'h5);
    wait_netin(1, {tbl[0].a, tbl[0].b}, 40, "reset_reach_wait");
    #2 reset = 1'b0;
    #1;
    chk("async_rst_net_in", net_in_b, 64'd0);
    chk("async_rst_irq_a", irq_a, 1'b0);
    bus_rd(1, 4'd3, q); chk("async_rst_stat_b", q, 32'd0);
    bus_rd(0, 4'd3, q); chk("async_rst_stat_a", q, 32'd0);
    bus_rd(1, 4'd4, q); chk("async_rst_ctrl_b", q, 32'd0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus_rd(1, 4'd3, q); chk("post_rst_stat_b", q, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
